// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: mode controller for a set-able wall clock.
// Turns five debounced button levels into single-cycle adjust pulses,
// produces the one-second advance pulse in RUN mode, and drives the
// display blink strobe while a field is being set. All outputs are flops.

module clock_mode_ctrl #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_center,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       en_clk,
    output logic       en_mins,
    output logic       en_hours,
    output logic       updown,
    output logic [1:0] mode,
    output logic       blink
);

    // Prescaler holds 0..TICK_DIV-1; the blink counter holds 0..TICK_DIV/2-1.
    localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HALF   = TICK_DIV / 2;
    localparam int HALF_W = (HALF > 2) ? $clog2(HALF) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

    // The state encoding doubles as the mode output code.
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_SET_MIN  = 2'b01;
    localparam logic [1:0] ST_SET_HOUR = 2'b10;

    // Bit positions inside the packed button vectors.
    localparam int B_CENTER = 4;
    localparam int B_LEFT   = 3;
    localparam int B_RIGHT  = 2;
    localparam int B_UP     = 1;
    localparam int B_DOWN   = 0;

    logic [4:0]        btn_q;
    logic [4:0]        btn_prev;
    logic [4:0]        btn_evt;
    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [PRE_W-1:0]  prescaler;
    logic [HALF_W-1:0] blink_cnt;
    logic              tick;
    logic              run_advance;
    logic              adj_min;
    logic              adj_hour;
    logic              updown_next;
    logic              evt_c;
    logic              evt_l;
    logic              evt_r;
    logic              evt_u;
    logic              evt_d;

    // Sample the buttons and keep the previous sample; both load 1 in reset
    // so a button held through reset cannot look like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q    <= '1;
            btn_prev <= '1;
        end else begin
            btn_q    <= {btn_center, btn_left, btn_right, btn_up, btn_down};
            btn_prev <= btn_q;
        end
    end

    assign btn_evt = btn_q & ~btn_prev;
    assign evt_c   = btn_evt[B_CENTER];
    assign evt_l   = btn_evt[B_LEFT];
    assign evt_r   = btn_evt[B_RIGHT];
    assign evt_u   = btn_evt[B_UP];
    assign evt_d   = btn_evt[B_DOWN];

    assign tick = (prescaler == PRE_LAST);

    // Resolve this cycle's button events by priority: center, then
    // left/right, then up/down; contradictory pairs cancel each other.
    always_comb begin
        state_next  = state;
        run_advance = 1'b0;
        adj_min     = 1'b0;
        adj_hour    = 1'b0;
        updown_next = updown;
        case (state)
            ST_RUN: begin
                if (evt_c) begin
                    state_next = ST_SET_MIN;
                end else begin
                    run_advance = 1'b1;
                end
            end
            ST_SET_MIN, ST_SET_HOUR: begin
                if (evt_c) begin
                    state_next = ST_RUN;
                end else if (evt_l || evt_r) begin
                    if (evt_l && !evt_r && state == ST_SET_MIN) begin
                        state_next = ST_SET_HOUR;
                    end else if (evt_r && !evt_l && state == ST_SET_HOUR) begin
                        state_next = ST_SET_MIN;
                    end
                end else if (evt_u != evt_d) begin
                    adj_min     = (state == ST_SET_MIN);
                    adj_hour    = (state == ST_SET_HOUR);
                    updown_next = evt_u;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (state_next == ST_RUN) begin
            updown_next = 1'b1;
        end
    end

    // Mode register; the mode output is this register directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    assign mode = state;

    // Seconds prescaler: counts only while staying in RUN, otherwise parked
    // at 0 so the first second after leaving a SET mode is a full one.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (run_advance) begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
        end else begin
            prescaler <= '0;
        end
    end

    // Registered pulse and direction outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_clk   <= 1'b0;
            en_mins  <= 1'b0;
            en_hours <= 1'b0;
            updown   <= 1'b1;
        end else begin
            en_clk   <= run_advance && tick;
            en_mins  <= adj_min;
            en_hours <= adj_hour;
            updown   <= updown_next;
        end
    end

    // Blink strobe: starts high on entry from RUN, then toggles every
    // TICK_DIV/2 cycles; a field switch keeps the running phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (state_next == ST_RUN) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else if (state == ST_RUN) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == HALF_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + HALF_W'(1);
        end
    end

endmodule
